// File: rtl/writeback_unit_pkg.sv
// Shared types for the writeback stage: register id, data word and queued write request.
package writeback_unit_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [REG_W-1:0] regid_t;

  typedef struct packed {
    regid_t rd;
    word_t  data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; pointers carry an extra wrap bit for full/empty.
module wb_fifo
  import writeback_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  wb_req_t                        push_data,
  input  logic                           pop,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output wb_req_t                        head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  wb_req_t        mem_q [DEPTH];
  wb_req_t        mem_d [DEPTH];
  logic           do_push_c, do_pop_c;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign count = CNT_W'(wr_ptr_q - rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Pointer advance and storage write for accepted push/pop.
  always_comb begin
    do_push_c = push && !full;
    do_pop_c  = pop && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    if (do_push_c) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
      wr_ptr_d                   = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (do_pop_c) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // Pointer registers; reset discards contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between valid pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results onto the single regfile write port and tracks outstanding loads.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [REG_W-1:0]              alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [REG_W-1:0]              ld_rd,
  input  logic [XLEN-1:0]               ld_data,
  input  logic                          iss_valid,
  input  logic [REG_W-1:0]              iss_rd,
  input  logic [REG_W-1:0]              rs1_addr,
  input  logic [REG_W-1:0]              rs2_addr,
  output logic                          rs1_pending,
  output logic                          rs2_pending,
  output logic                          w_enable,
  output logic [REG_W-1:0]              w_addr,
  output logic [XLEN-1:0]               w_data,
  output logic [$clog2(LQ_DEPTH+1)-1:0] lq_count
);

  wb_req_t              lq_head;
  wb_req_t              ld_req_c;
  wb_req_t              sel_c;
  logic                 lq_full, lq_empty;
  logic                 sel_valid_c, lq_push_c, lq_pop_c, ld_acc_c;
  logic                 w_enable_q, w_enable_d;
  regid_t               w_addr_q, w_addr_d;
  word_t                w_data_q, w_data_d;
  logic [NUM_REGS-1:0]  pending_q, pending_d;

  assign ld_req_c = '{rd: ld_rd, data: ld_data};

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk       (clk),
    .rst       (rst),
    .push      (lq_push_c),
    .push_data (ld_req_c),
    .pop       (lq_pop_c),
    .full      (lq_full),
    .empty     (lq_empty),
    .count     (lq_count),
    .head      (lq_head)
  );

  // Accept loads only from registered occupancy; no pop-to-push pass-through.
  assign ld_ready = !rst && !lq_full;

  // Priority select: ALU, then queue head, then an incoming load when the queue is empty.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_c       = '0;
    lq_pop_c    = 1'b0;
    ld_acc_c    = ld_valid && ld_ready;
    if (alu_valid) begin
      sel_valid_c = 1'b1;
      sel_c       = '{rd: alu_rd, data: alu_data};
    end else if (!lq_empty) begin
      sel_valid_c = 1'b1;
      sel_c       = lq_head;
      lq_pop_c    = 1'b1;
    end else if (ld_acc_c) begin
      sel_valid_c = 1'b1;
      sel_c       = ld_req_c;
    end
    lq_push_c = ld_acc_c && (alu_valid || !lq_empty);
  end

  // Writes to x0 are dropped here because the regfile does not protect it.
  always_comb begin
    w_enable_d = sel_valid_c && (sel_c.rd != '0);
    w_addr_d   = sel_c.rd;
    w_data_d   = sel_c.data;
  end

  // Pending scoreboard: clear on commit of the registered write, set on issue (set wins).
  always_comb begin
    pending_d = pending_q;
    if (w_enable_q) begin
      pending_d[w_addr_q] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      pending_d[iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Output register and scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_enable_q <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      pending_q  <= '0;
    end else begin
      w_enable_q <= w_enable_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      pending_q  <= pending_d;
    end
  end

  assign w_enable    = w_enable_q;
  assign w_addr      = w_addr_q;
  assign w_data      = w_data_q;
  assign rs1_pending = pending_q[rs1_addr];
  assign rs2_pending = pending_q[rs2_addr];

endmodule
